answer_judge: RTL and testbench

Quiz-game answer checker that sits directly upstream of the dot-matrix display driver. It collects BCD digits from the keypad decoder, compares the submitted entry against a target code latched at round start, and limits the player to a fixed number of attempts. It emits the `correct`, `wrong` and `fail` strobes/levels that the display driver consumes. It also exposes the live entry buffer for the 7-segment stage.

---
 rtl/answer_judge.sv | 119 +++++++++++
 tb/tb_answer_judge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/answer_judge.sv
// Quiz answer checker: buffers BCD keypad digits, compares the submission with a
// target latched at round start, and limits the player to MAX_TRY attempts.
module answer_judge #(
  parameter int DIGITS  = 4,
  parameter int MAX_TRY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   target,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [3:0]            correct,
  output logic [3:0]            wrong,
  output logic [3:0]            fail,
  output logic [4*DIGITS-1:0]   entry,
  output logic [3:0]            entry_len,
  output logic [3:0]            tries_left,
  output logic                  busy
);

  localparam int         W     = 4 * DIGITS;
  localparam logic [3:0] DIG_N = 4'(DIGITS);
  localparam logic [3:0] TRY_N = 4'(MAX_TRY);
  localparam logic [3:0] KEY_BS    = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  typedef enum logic [2:0] {IDLE, ENTRY, CHECK, WIN, LOSE} state_t;

  state_t         state, state_n;
  logic [W-1:0]   target_q, target_n, entry_n;
  logic [3:0]     len_n, tries_n;
  logic           correct_n, wrong_n, fail_n;

  // All outputs come straight from flops so the display driver sees clean edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      target_q   <= '0;
      entry      <= '0;
      entry_len  <= '0;
      tries_left <= '0;
      correct    <= '0;
      wrong      <= '0;
      fail       <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      target_q   <= target_n;
      entry      <= entry_n;
      entry_len  <= len_n;
      tries_left <= tries_n;
      correct    <= {3'b000, correct_n};
      wrong      <= {3'b000, wrong_n};
      fail       <= {3'b000, fail_n};
      busy       <= (state_n == ENTRY) || (state_n == CHECK);
    end
  end

  always_comb begin
    state_n   = state;
    target_n  = target_q;
    entry_n   = entry;
    len_n     = entry_len;
    tries_n   = tries_left;
    correct_n = correct[0];
    fail_n    = fail[0];
    wrong_n   = 1'b0;
    if (start) begin
      // A new round overrides everything, including a key arriving on the same cycle.
      target_n  = target;
      entry_n   = '0;
      len_n     = '0;
      tries_n   = TRY_N;
      correct_n = 1'b0;
      fail_n    = 1'b0;
      state_n   = ENTRY;
    end else begin
      case (state)
        ENTRY: begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (entry_len < DIG_N) begin
                entry_n = W'({entry, key_code});
                len_n   = entry_len + 4'd1;
              end
            end else if (key_code == KEY_BS) begin
              if (entry_len != 4'd0) begin
                entry_n = entry >> 4;
                len_n   = entry_len - 4'd1;
              end
            end else if (key_code == KEY_ENTER) begin
              if (entry_len == DIG_N) state_n = CHECK;
            end
          end
        end
        CHECK: begin
          if (entry == target_q) begin
            correct_n = 1'b1;
            state_n   = WIN;
          end else begin
            wrong_n = 1'b1;
            tries_n = tries_left - 4'd1;
            entry_n = '0;
            len_n   = '0;
            if (tries_n == 4'd0) begin
              fail_n  = 1'b1;
              state_n = LOSE;
            end else begin
              state_n = ENTRY;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_answer_judge.sv
// Directed bench for answer_judge: default instance plus a DIGITS=1/MAX_TRY=1 instance,
// expected outputs queued at drive time and checked one edge later.
module tb_answer_judge;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, kv_a, start_b, kv_b;
  logic [15:0] target_a;
  logic [3:0]  target_b, kc_a, kc_b;
  logic [3:0]  correct_a, wrong_a, fail_a, len_a, tries_a;
  logic [15:0] entry_a;
  logic        busy_a;
  logic [3:0]  correct_b, wrong_b, fail_b, len_b, tries_b, entry_b;
  logic        busy_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [3:0]  correct, wrong, fail;
    logic [15:0] entry;
    logic [3:0]  len, tries;
    logic        busy;
  } exp_t;

  exp_t q[$];

  answer_judge #(.DIGITS(4), .MAX_TRY(3)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .target(target_a),
    .key_valid(kv_a), .key_code(kc_a), .correct(correct_a), .wrong(wrong_a),
    .fail(fail_a), .entry(entry_a), .entry_len(len_a), .tries_left(tries_a), .busy(busy_a)
  );

  answer_judge #(.DIGITS(1), .MAX_TRY(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .target(target_b),
    .key_valid(kv_b), .key_code(kc_b), .correct(correct_b), .wrong(wrong_b),
    .fail(fail_b), .entry(entry_b), .entry_len(len_b), .tries_left(tries_b), .busy(busy_b)
  );

  always #20 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [3:0] c, input logic [3:0] w,
                          input logic [3:0] f, input logic [15:0] e, input logic [3:0] l,
                          input logic [3:0] t, input logic b);
    exp_t x;
    x.tag = tag; x.correct = c; x.wrong = w; x.fail = f;
    x.entry = e; x.len = l; x.tries = t; x.busy = b;
    q.push_back(x);
  endtask

  task automatic chk(input bit sel);
    exp_t x;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    x = q.pop_front();
    if (!sel) begin
      cmp({x.tag, ".correct"}, 32'(correct_a), 32'(x.correct));
      cmp({x.tag, ".wrong"},   32'(wrong_a),   32'(x.wrong));
      cmp({x.tag, ".fail"},    32'(fail_a),    32'(x.fail));
      cmp({x.tag, ".entry"},   32'(entry_a),   32'(x.entry));
      cmp({x.tag, ".len"},     32'(len_a),     32'(x.len));
      cmp({x.tag, ".tries"},   32'(tries_a),   32'(x.tries));
      cmp({x.tag, ".busy"},    32'(busy_a),    32'(x.busy));
    end else begin
      cmp({x.tag, ".correct"}, 32'(correct_b), 32'(x.correct));
      cmp({x.tag, ".wrong"},   32'(wrong_b),   32'(x.wrong));
      cmp({x.tag, ".fail"},    32'(fail_b),    32'(x.fail));
      cmp({x.tag, ".entry"},   32'(entry_b),   32'(x.entry));
      cmp({x.tag, ".len"},     32'(len_b),     32'(x.len));
      cmp({x.tag, ".tries"},   32'(tries_b),   32'(x.tries));
      cmp({x.tag, ".busy"},    32'(busy_b),    32'(x.busy));
    end
  endtask

  // Drive one cycle of stimulus to the selected instance, then check one edge later.
  task automatic step(input bit sel, input logic st, input logic [15:0] tg, input logic kv,
                      input logic [3:0] kc, input string tag, input logic [3:0] c,
                      input logic [3:0] w, input logic [3:0] f, input logic [15:0] e,
                      input logic [3:0] l, input logic [3:0] t, input logic b);
    start_a = 1'b0; kv_a = 1'b0; kc_a = 4'h0; target_a = 16'h0;
    start_b = 1'b0; kv_b = 1'b0; kc_b = 4'h0; target_b = 4'h0;
    if (!sel) begin
      start_a = st; target_a = tg; kv_a = kv; kc_a = kc;
    end else begin
      start_b = st; target_b = tg[3:0]; kv_b = kv; kc_b = kc;
    end
    push_exp(tag, c, w, f, e, l, t, b);
    @(posedge clk);
    #1;
    chk(sel);
  endtask

  initial begin
    logic [15:0] e;
    reset = 1'b1;
    start_a = 1'b0; kv_a = 1'b0; kc_a = 4'h0; target_a = 16'h0;
    start_b = 1'b0; kv_b = 1'b0; kc_b = 4'h0; target_b = 4'h0;
    #50;
    push_exp("rst_a", 0, 0, 0, 16'h0, 0, 0, 0); chk(0);
    push_exp("rst_b", 0, 0, 0, 16'h0, 0, 0, 0); chk(1);
    reset = 1'b0;

    // Round won on first attempt
    step(0, 1, 16'h1234, 0, 4'h0, "t1_start", 0, 0, 0, 16'h0000, 0, 3, 1);
    step(0, 0, 16'h0, 1, 4'h1, "t1_k1", 0, 0, 0, 16'h0001, 1, 3, 1);
    step(0, 0, 16'h0, 1, 4'h2, "t1_k2", 0, 0, 0, 16'h0012, 2, 3, 1);
    step(0, 0, 16'h0, 1, 4'h3, "t1_k3", 0, 0, 0, 16'h0123, 3, 3, 1);
    step(0, 0, 16'h0, 1, 4'h4, "t1_k4", 0, 0, 0, 16'h1234, 4, 3, 1);
    step(0, 0, 16'h0, 1, 4'hB, "t1_enter", 0, 0, 0, 16'h1234, 4, 3, 1);
    step(0, 0, 16'h0, 0, 4'h0, "t1_verdict", 1, 0, 0, 16'h1234, 4, 3, 0);
    step(0, 0, 16'h0, 1, 4'h5, "t1_win_key", 1, 0, 0, 16'h1234, 4, 3, 0);

    // Three wrong attempts exhaust the round
    step(0, 1, 16'h1234, 0, 4'h0, "t2_start", 0, 0, 0, 16'h0000, 0, 3, 1);
    for (int r = 1; r <= 3; r++) begin
      e = 16'h0;
      for (int k = 1; k <= 4; k++) begin
        e = {e[11:0], 4'(r)};
        step(0, 0, 16'h0, 1, 4'(r), $sformatf("t2_r%0d_k%0d", r, k), 0, 0, 0, e, 4'(k), 4'(4 - r), 1);
      end
      step(0, 0, 16'h0, 1, 4'hB, $sformatf("t2_r%0d_enter", r), 0, 0, 0, e, 4, 4'(4 - r), 1);
      if (r < 3)
        step(0, 0, 16'h0, 0, 4'h0, $sformatf("t2_r%0d_wrong", r), 0, 1, 0, 16'h0, 0, 4'(3 - r), 1);
      else
        step(0, 0, 16'h0, 0, 4'h0, "t2_r3_fail", 0, 1, 1, 16'h0, 0, 0, 0);
    end
    step(0, 0, 16'h0, 1, 4'h5, "t2_lose_key", 0, 0, 1, 16'h0, 0, 0, 0);
    step(0, 0, 16'h0, 1, 4'hB, "t2_lose_enter", 0, 0, 1, 16'h0, 0, 0, 0);

    // Buffer full, backspace, short enter
    step(0, 1, 16'h1234, 0, 4'h0, "t3_start", 0, 0, 0, 16'h0000, 0, 3, 1);
    step(0, 0, 16'h0, 1, 4'h9, "t3_k9", 0, 0, 0, 16'h0009, 1, 3, 1);
    step(0, 0, 16'h0, 1, 4'h8, "t3_k8", 0, 0, 0, 16'h0098, 2, 3, 1);
    step(0, 0, 16'h0, 1, 4'h7, "t3_k7", 0, 0, 0, 16'h0987, 3, 3, 1);
    step(0, 0, 16'h0, 1, 4'h6, "t3_k6", 0, 0, 0, 16'h9876, 4, 3, 1);
    step(0, 0, 16'h0, 1, 4'h5, "t3_full", 0, 0, 0, 16'h9876, 4, 3, 1);
    step(0, 0, 16'h0, 1, 4'hA, "t3_bs1", 0, 0, 0, 16'h0987, 3, 3, 1);
    step(0, 0, 16'h0, 1, 4'hA, "t3_bs2", 0, 0, 0, 16'h0098, 2, 3, 1);
    step(0, 0, 16'h0, 1, 4'hB, "t3_short_enter", 0, 0, 0, 16'h0098, 2, 3, 1);
    step(0, 0, 16'h0, 0, 4'h0, "t3_no_check", 0, 0, 0, 16'h0098, 2, 3, 1);
    step(0, 0, 16'h0, 1, 4'hC, "t3_code_c", 0, 0, 0, 16'h0098, 2, 3, 1);
    step(0, 0, 16'h0, 1, 4'hA, "t3_bs3", 0, 0, 0, 16'h0009, 1, 3, 1);
    step(0, 0, 16'h0, 1, 4'hA, "t3_bs4", 0, 0, 0, 16'h0000, 0, 3, 1);
    step(0, 0, 16'h0, 1, 4'hA, "t3_bs5", 0, 0, 0, 16'h0000, 0, 3, 1);

    // Restart with simultaneous key, then zero target
    step(0, 1, 16'h1234, 0, 4'h0, "t4_start", 0, 0, 0, 16'h0000, 0, 3, 1);
    step(0, 0, 16'h0, 1, 4'h1, "t4_k1", 0, 0, 0, 16'h0001, 1, 3, 1);
    step(0, 0, 16'h0, 1, 4'h1, "t4_k2", 0, 0, 0, 16'h0011, 2, 3, 1);
    step(0, 0, 16'h0, 1, 4'h1, "t4_k3", 0, 0, 0, 16'h0111, 3, 3, 1);
    step(0, 0, 16'h0, 1, 4'h1, "t4_k4", 0, 0, 0, 16'h1111, 4, 3, 1);
    step(0, 0, 16'h0, 1, 4'hB, "t4_enter", 0, 0, 0, 16'h1111, 4, 3, 1);
    step(0, 0, 16'h0, 0, 4'h0, "t4_wrong", 0, 1, 0, 16'h0000, 0, 2, 1);
    step(0, 1, 16'h0000, 1, 4'h5, "t4_restart", 0, 0, 0, 16'h0000, 0, 3, 1);
    for (int k = 1; k <= 4; k++)
      step(0, 0, 16'h0, 1, 4'h0, $sformatf("t4_z%0d", k), 0, 0, 0, 16'h0000, 4'(k), 3, 1);
    step(0, 0, 16'h0, 1, 4'hB, "t4_z_enter", 0, 0, 0, 16'h0000, 4, 3, 1);
    step(0, 0, 16'h0, 0, 4'h0, "t4_z_win", 1, 0, 0, 16'h0000, 4, 3, 0);

    // Asynchronous reset while in CHECK
    step(0, 1, 16'h1234, 0, 4'h0, "t5_start", 0, 0, 0, 16'h0000, 0, 3, 1);
    step(0, 0, 16'h0, 1, 4'h1, "t5_k1", 0, 0, 0, 16'h0001, 1, 3, 1);
    step(0, 0, 16'h0, 1, 4'h2, "t5_k2", 0, 0, 0, 16'h0012, 2, 3, 1);
    step(0, 0, 16'h0, 1, 4'h3, "t5_k3", 0, 0, 0, 16'h0123, 3, 3, 1);
    step(0, 0, 16'h0, 1, 4'h5, "t5_k4", 0, 0, 0, 16'h1235, 4, 3, 1);
    step(0, 0, 16'h0, 1, 4'hB, "t5_enter", 0, 0, 0, 16'h1235, 4, 3, 1);
    kv_a = 1'b0;
    #5 reset = 1'b1;
    #1;
    push_exp("t5_async_rst", 0, 0, 0, 16'h0, 0, 0, 0); chk(0);
    #2 reset = 1'b0;
    step(0, 0, 16'h0, 1, 4'h1, "t5_idle_key", 0, 0, 0, 16'h0000, 0, 0, 0);
    step(0, 0, 16'h0, 1, 4'hB, "t5_idle_enter", 0, 0, 0, 16'h0000, 0, 0, 0);
    step(0, 1, 16'h1234, 0, 4'h0, "t5_start2", 0, 0, 0, 16'h0000, 0, 3, 1);
    step(0, 0, 16'h0, 1, 4'h4, "t5_k_after", 0, 0, 0, 16'h0004, 1, 3, 1);

    // Single-digit, single-attempt instance
    step(1, 1, 16'h0007, 0, 4'h0, "t6_start", 0, 0, 0, 16'h0, 0, 1, 1);
    step(1, 0, 16'h0, 1, 4'h3, "t6_k3", 0, 0, 0, 16'h3, 1, 1, 1);
    step(1, 0, 16'h0, 1, 4'h4, "t6_full", 0, 0, 0, 16'h3, 1, 1, 1);
    step(1, 0, 16'h0, 1, 4'hB, "t6_enter", 0, 0, 0, 16'h3, 1, 1, 1);
    step(1, 0, 16'h0, 0, 4'h0, "t6_fail", 0, 1, 1, 16'h0, 0, 0, 0);
    step(1, 0, 16'h0, 0, 4'h0, "t6_hold", 0, 0, 1, 16'h0, 0, 0, 0);
    step(1, 1, 16'h0007, 0, 4'h0, "t6_start2", 0, 0, 0, 16'h0, 0, 1, 1);
    step(1, 0, 16'h0, 1, 4'h7, "t6_k7", 0, 0, 0, 16'h7, 1, 1, 1);
    step(1, 0, 16'h0, 1, 4'hB, "t6_enter2", 0, 0, 0, 16'h7, 1, 1, 1);
    step(1, 0, 16'h0, 0, 4'h0, "t6_win", 1, 0, 0, 16'h7, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
